// File: rtl/mul_pkg.sv
// Shared constants and FSM state type for the multiply-accumulate stage.
package mul_pkg;

  localparam int unsigned ACC_W_DEF = 40;
  localparam int unsigned PROD_W    = 32;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mul_cpa.sv
// Carry-propagate adder that resolves the Wallace-tree sum/carry pair into one product.
module mul_cpa
  import mul_pkg::*;
(
  input  logic [PROD_W-1:0] a,
  input  logic [PROD_W-1:0] b,
  output logic [PROD_W-1:0] s
);

  always_comb begin
    s = a + b;
  end

endmodule

// File: rtl/mul_acc_stage.sv
// Two-stage frame accumulator: register a sum/carry term, resolve it and add it into acc.
// Build option MUL_ACC_SAT_EN clamps an overflowing accumulation instead of wrapping.
module mul_acc_stage
  import mul_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] sum,
  input  logic [PROD_W-1:0] carry,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_ovf
);

  if (ACC_W < 33 || ACC_W > 64) begin : g_acc_w_check
    $error("mul_acc_stage: ACC_W must lie in 33..64");
  end

  state_t              r_state;
  state_t              w_state_nxt;

  logic [PROD_W-1:0]   r_s1_sum;
  logic [PROD_W-1:0]   r_s1_carry;
  logic                r_s1_last;
  logic                r_s1_valid;

  logic [ACC_W-1:0]    r_acc;
  logic                r_ovf;

  logic                w_accept;
  logic                w_consume;
  logic                w_release;
  logic [PROD_W-1:0]   w_prod;
  logic [ACC_W-1:0]    w_prod_ext;
  logic [ACC_W:0]      w_sum_wide;
  logic                w_add_ovf;
  logic [ACC_W-1:0]    w_acc_nxt;

  mul_cpa u_cpa (
    .a (r_s1_sum),
    .b (r_s1_carry),
    .s (w_prod)
  );

  // s1 may fill once while HOLD is presented, so ready only drops when it is occupied.
  always_comb begin
    in_ready  = (r_state == ST_ACC) || !r_s1_valid;
    w_accept  = in_valid && in_ready;
    w_consume = (r_state == ST_ACC) && r_s1_valid;
    out_valid = (r_state == ST_HOLD);
    acc_out   = r_acc;
    acc_ovf   = r_ovf;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    unique case (r_state)
      ST_ACC: begin
        if (w_consume && r_s1_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          w_state_nxt = ST_ACC;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_ACC;
    endcase
  end

  // One guard bit above the accumulator exposes signed overflow as a top-two-bit mismatch.
  always_comb begin
    w_prod_ext = {{(ACC_W - PROD_W){w_prod[PROD_W-1]}}, w_prod};
    w_sum_wide = {r_acc[ACC_W-1], r_acc} + {w_prod_ext[ACC_W-1], w_prod_ext};
    w_add_ovf  = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
`ifdef MUL_ACC_SAT_EN
    if (w_add_ovf) begin
      w_acc_nxt = w_sum_wide[ACC_W] ? {1'b1, {(ACC_W - 1){1'b0}}}
                                    : {1'b0, {(ACC_W - 1){1'b1}}};
    end else begin
      w_acc_nxt = w_sum_wide[ACC_W-1:0];
    end
`else
    w_acc_nxt = w_sum_wide[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_sum   <= '0;
      r_s1_carry <= '0;
      r_s1_last  <= 1'b0;
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_sum   <= sum;
      r_s1_carry <= carry;
      r_s1_last  <= in_last;
      r_s1_valid <= 1'b1;
    end else if (w_consume) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_release) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (w_consume) begin
      r_acc <= w_acc_nxt;
      r_ovf <= r_ovf | w_add_ovf;
    end
  end

endmodule

// File: tb/tb_mul_acc_stage.sv
// Directed and randomized self-checking bench for mul_acc_stage (ACC_W=40 and ACC_W=33 instances).
module tb_mul_acc_stage;

  logic        clk;
  logic        rst_n;

  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_acc_ovf;
  logic [31:0] a_sum, a_carry;
  logic [39:0] a_acc_out;

  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_acc_ovf;
  logic [31:0] b_sum, b_carry;
  logic [32:0] b_acc_out;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [63:0] exp_q[$];
  bit          rnd_done = 0;

  mul_acc_stage #(.ACC_W(40)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .sum(a_sum), .carry(a_carry), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .acc_out(a_acc_out), .acc_ovf(a_acc_ovf)
  );

  mul_acc_stage #(.ACC_W(33)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .sum(b_sum), .carry(b_carry), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .acc_out(b_acc_out), .acc_ovf(b_acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present one term and return #1 after the edge that accepted it.
  task automatic send(input bit sel, input logic [31:0] s, input logic [31:0] c,
                      input logic last);
    int unsigned k;
    if (!sel) begin
      a_sum = s; a_carry = c; a_in_last = last; a_in_valid = 1'b1;
    end else begin
      b_sum = s; b_carry = c; b_in_last = last; b_in_valid = 1'b1;
    end
    k = 0;
    @(negedge clk);
    while (!(sel ? b_in_ready : a_in_ready) && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready low for 50 cycles, required 1");
    end
    @(posedge clk);
    #1;
    if (!sel) a_in_valid = 1'b0;
    else      b_in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit sel, input string tag);
    int unsigned k;
    k = 0;
    while (!(sel ? b_out_valid : a_out_valid) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!(sel ? b_out_valid : a_out_valid)) begin
      n_chk++;
      $display("FAIL %s: out_valid 0 after 20 cycles, required 1", tag);
    end
  endtask

  task automatic release_out(input bit sel, input string tag);
    if (!sel) a_out_ready = 1'b1;
    else      b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (!sel) begin
      a_out_ready = 1'b0;
      chk({tag, "_ov_clr"}, a_out_valid, 0);
      chk({tag, "_acc_clr"}, a_acc_out, 0);
    end else begin
      b_out_ready = 1'b0;
      chk({tag, "_ov_clr"}, b_out_valid, 0);
      chk({tag, "_ovf_clr"}, b_acc_ovf, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 0; a_sum = '0; a_carry = '0; a_in_last = 0; a_out_ready = 0;
    b_in_valid = 0; b_sum = '0; b_carry = '0; b_in_last = 0; b_out_ready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_acc", a_acc_out, 0);
    chk("rst_ovf", a_acc_ovf, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single negative term: -6 two cycles after acceptance
    send(0, 32'hFFFF_FFFA, 32'h0, 1'b1);
    chk("t1_ov_early", a_out_valid, 0);
    @(posedge clk); #1;
    chk("t1_ov", a_out_valid, 1);
    chk("t1_acc", a_acc_out, 40'hFF_FFFF_FFFA);
    chk("t1_ovf", a_acc_ovf, 0);
    chk("t1_hold_rdy", a_in_ready, 1);
    release_out(0, "t1");

    // Four back-to-back terms: 100, -30, 7, 0x3FFF0001
    send(0, 32'd60, 32'd40, 1'b0);
    chk("t2_rdy0", a_in_ready, 1);
    send(0, 32'hFFFF_FF00, 32'h0000_00E2, 1'b0);
    chk("t2_rdy1", a_in_ready, 1);
    send(0, 32'd3, 32'd4, 1'b0);
    chk("t2_rdy2", a_in_ready, 1);
    send(0, 32'h3FFF_0000, 32'h1, 1'b1);
    chk("t2_ov_early", a_out_valid, 0);
    @(posedge clk); #1;
    chk("t2_ov", a_out_valid, 1);
    chk("t2_acc", a_acc_out, 40'h00_3FFF_004E);
    release_out(0, "t2");

    // Stalled HOLD: one term absorbed, second waits, next frame = 11 + 22
    send(0, 32'd9, 32'd0, 1'b1);
    @(posedge clk); #1;
    chk("t3_ov", a_out_valid, 1);
    send(0, 32'd5, 32'd6, 1'b0);
    chk("t3_rdy_full", a_in_ready, 0);
    fork
      send(0, 32'd20, 32'd2, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("t3_stall_acc", a_acc_out, 40'd9);
          chk("t3_stall_ov", a_out_valid, 1);
          chk("t3_stall_rdy", a_in_ready, 0);
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        chk("t3_clr_acc", a_acc_out, 0);
        chk("t3_clr_ov", a_out_valid, 0);
      end
    join
    wait_out(0, "t3_wait");
    chk("t3_acc", a_acc_out, 40'd33);
    release_out(0, "t3");

    // ACC_W=33: exact positive limit, then overflow with sticky flag
    send(1, 32'h7FFF_FFF0, 32'hF, 1'b0);
    send(1, 32'h7FFF_FFF0, 32'hF, 1'b1);
    @(posedge clk); #1;
    chk("t4a_ov", b_out_valid, 1);
    chk("t4a_acc", b_acc_out, 33'h0_FFFF_FFFE);
    chk("t4a_ovf", b_acc_ovf, 0);
    release_out(1, "t4a");
    send(1, 32'h7FFF_FFF0, 32'hF, 1'b0);
    send(1, 32'h7FFF_FFF0, 32'hF, 1'b0);
    send(1, 32'h7FFF_FFF0, 32'hF, 1'b0);
    send(1, 32'hFFFF_FFFE, 32'h1, 1'b1);
    @(posedge clk); #1;
    chk("t4b_ov", b_out_valid, 1);
    chk("t4b_ovf", b_acc_ovf, 1);
`ifdef MUL_ACC_SAT_EN
    chk("t4b_acc", b_acc_out, 33'h0_FFFF_FFFE);
`else
    chk("t4b_acc", b_acc_out, 33'h1_7FFF_FFFC);
`endif
    release_out(1, "t4b");

    // Asynchronous reset mid-frame, then a fresh frame of 5
    send(0, 32'd1, 32'd2, 1'b0);
    send(0, 32'd2, 32'd2, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_ov", a_out_valid, 0);
    chk("t5_rst_acc", a_acc_out, 0);
    chk("t5_rst_rdy", a_in_ready, 1);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_stale", a_out_valid, 0);
    end
    @(posedge clk); #1;
    send(0, 32'd2, 32'd3, 1'b1);
    wait_out(0, "t5_wait");
    chk("t5_acc", a_acc_out, 40'd5);
    release_out(0, "t5");

    // Random products, random splits and stalls against a queue scoreboard
    fork
      begin : drv
        logic signed [15:0] ma, mb;
        logic signed [31:0] p;
        logic [31:0]        s;
        longint             acc;
        int unsigned        len;
        for (int f = 0; f < 1000 && !rnd_done; f++) begin
          len = $urandom_range(1, 4);
          acc = 0;
          for (int t = 0; t < int'(len); t++) begin
            ma = 16'($urandom);
            mb = 16'($urandom);
            p  = ma * mb;
            s  = $urandom;
            acc = acc + longint'(p);
            if (t == int'(len) - 1) exp_q.push_back(64'(acc));
            send(0, s, 32'(p) - s, (t == int'(len) - 1));
            if ($urandom_range(0, 3) == 0) begin
              repeat ($urandom_range(1, 3)) @(posedge clk);
              #1;
            end
          end
        end
      end
      begin : rdy
        while (!rnd_done) begin
          @(posedge clk); #1;
          a_out_ready = ($urandom_range(0, 1) == 1);
        end
        a_out_ready = 1'b0;
      end
      begin : mon
        int unsigned got, cyc;
        logic [63:0] e;
        got = 0;
        cyc = 0;
        while (got < 1000 && cyc < 40000) begin
          @(negedge clk);
          cyc++;
          if (a_out_valid && a_out_ready) begin
            if (exp_q.size() == 0) begin
              n_chk++;
              $display("FAIL rnd_extra: result 0x%0h with no frame outstanding", a_acc_out);
            end else begin
              e = exp_q.pop_front();
              chk("rnd_acc", a_acc_out, {24'h0, e[39:0]});
            end
            got++;
          end
        end
        if (got < 1000) begin
          n_chk++;
          $display("FAIL rnd_timeout: %0d frames seen, required 1000", got);
        end
        rnd_done = 1;
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
